// File: rtl/axi_stream_output_packed_pkg.sv
// Shared constants and state type for the packed AXI4-Stream output stage.
package axi_stream_output_packed_pkg;

    localparam int unsigned DEF_CHAR_LEN = 8;
    localparam int unsigned DEF_N        = 8;
    localparam int unsigned OUT_PACK     = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_t;

endpackage

// File: rtl/axi_stream_output_packed.sv
// Captures an N-character frame on run/ready and streams it as AXI4-Stream,
// PACK characters per beat, with TKEEP trimming the final partial beat.
module axi_stream_output_packed
    import axi_stream_output_packed_pkg::*;
#(
    parameter int unsigned CHAR_LEN = DEF_CHAR_LEN,
    parameter int unsigned N        = DEF_N,
    parameter int unsigned PACK     = OUT_PACK,
    parameter int unsigned LEN_W    = $clog2(N + 1)
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic                         run,
    input  logic [N*CHAR_LEN-1:0]        d,
    input  logic [LEN_W-1:0]             len,
    output logic                         ready,
    output logic                         valid,
    output logic [PACK*CHAR_LEN-1:0]     M_AXIS_TDATA,
    output logic [PACK*CHAR_LEN/8-1:0]   M_AXIS_TKEEP,
    output logic                         M_AXIS_TLAST,
    output logic                         M_AXIS_TVALID,
    input  logic                         M_AXIS_TREADY
);

    localparam int unsigned BEATS  = N / PACK;
    localparam int unsigned BEAT_W = PACK * CHAR_LEN;
    localparam int unsigned CB     = CHAR_LEN / 8;
    localparam int unsigned IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [LEN_W-1:0] N_L    = LEN_W'(N);
    localparam logic [LEN_W-1:0] PACK_L = LEN_W'(PACK);

    if ((N % PACK) != 0) begin : g_bad_pack
        $error("axi_stream_output_packed: N must be a multiple of PACK");
    end
    if ((CHAR_LEN % 8) != 0) begin : g_bad_char
        $error("axi_stream_output_packed: CHAR_LEN must be a multiple of 8");
    end

    state_t                         state;
    state_t                         state_nxt;
    logic [BEATS-1:0][BEAT_W-1:0]   frame;
    logic [LEN_W-1:0]               rem;
    logic [LEN_W-1:0]               len_clamped;
    logic [LEN_W-1:0]               keep_chars;
    logic [IDX_W-1:0]               idx;
    logic                           send;
    logic                           last;
    logic                           load;
    logic                           beat_done;

    assign len_clamped = (len > N_L) ? N_L : len;
    assign send        = (state == ST_SEND);
    assign last        = (rem <= PACK_L);
    assign load        = (state == ST_IDLE) && run;
    assign beat_done   = send && M_AXIS_TREADY;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= ST_IDLE;
            frame <= '0;
            rem   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                frame <= d;
                rem   <= len_clamped;
                idx   <= '0;
            end else if (beat_done && !last) begin
                idx <= idx + IDX_W'(1);
                rem <= rem - PACK_L;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (run) state_nxt = (len_clamped == '0) ? ST_DONE : ST_SEND;
            ST_SEND: if (M_AXIS_TREADY && last) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // All stream outputs are decoded from registered state; zero outside SEND.
    always_comb begin
        ready         = (state == ST_IDLE);
        valid         = (state == ST_DONE);
        M_AXIS_TVALID = send;
        M_AXIS_TLAST  = send && last;
        M_AXIS_TDATA  = send ? frame[idx] : '0;
        keep_chars    = last ? rem : PACK_L;
        M_AXIS_TKEEP  = '0;
        if (send) begin
            for (int unsigned k = 0; k < PACK; k++) begin
                if (LEN_W'(k) < keep_chars) begin
                    M_AXIS_TKEEP[k*CB +: CB] = '1;
                end
            end
        end
    end

endmodule
